// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Define FIFO_STATUS_EN to expose occupancy count and sticky overflow/underflow flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic                    full,
  input  logic                    read_en,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    empty
`ifdef FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           occ;
  logic                  wr_accept;
  logic                  rd_accept;

  assign full  = (occ == FULL_COUNT);
  assign empty = (occ == '0);

  // A read frees a slot in the same edge, so a full FIFO can still take a write.
  assign rd_accept = read_en & ~empty;
  assign wr_accept = write_en & (~full | rd_accept);

  always_ff @(posedge clk) begin
    if (wr_accept && !reset) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      read_data <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr    <= rd_ptr + 1'b1;
        read_data <= mem[rd_ptr];
      end
      case ({wr_accept, rd_accept})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef FIFO_STATUS_EN
  assign count = occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && !wr_accept) begin
        overflow <= 1'b1;
      end
      if (read_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed vector table, a corner-case
// sequence, then randomized traffic against a queue-based reference model.
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          write_en;
  logic [DW-1:0] write_data;
  logic          full;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          empty;
`ifdef FIFO_STATUS_EN
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
`endif

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .write_data (write_data),
    .full       (full),
    .read_en    (read_en),
    .read_data  (read_data),
    .empty      (empty)
`ifdef FIFO_STATUS_EN
    ,
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a queue holding the stored words in arrival order.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  bit            m_ovf;
  bit            m_unf;

  typedef struct {
    logic          r;
    logic          we;
    logic [DW-1:0] wd;
    logic          re;
    logic          e;
    logic          f;
    logic [DW-1:0] rd;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic r, input logic we, input logic [DW-1:0] wd,
                              input logic re, input logic e, input logic f,
                              input logic [DW-1:0] rd);
    vec_t v;
    v.r = r; v.we = we; v.wd = wd; v.re = re; v.e = e; v.f = f; v.rd = rd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [DW-1:0] wd, input logic re);
    bit rd_ok;
    bit wr_ok;
    reset = r; write_en = we; write_data = wd; read_en = re;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_rd  = '0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      rd_ok = re && (q.size() > 0);
      wr_ok = we && ((q.size() < DEPTH) || rd_ok);
      if (we && !wr_ok) m_ovf = 1;
      if (re && q.size() == 0) m_unf = 1;
      if (rd_ok) m_rd = q.pop_front();
      if (wr_ok) q.push_back(wd);
    end
    reset = 0; write_en = 0; read_en = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, "_rdata"}, 32'(read_data), 32'(m_rd));
`ifdef FIFO_STATUS_EN
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_unf"}, 32'(underflow), 32'(m_unf));
`endif
  endtask

  initial begin
    reset = 1; write_en = 0; write_data = '0; read_en = 0;
    m_rd = '0; m_ovf = 0; m_unf = 0;

    // Directed sequence: reset, fill, overflow, drain, underflow, wrap, concurrent, mid reset.
    add(1, 0, 8'h00, 0, 1, 0, 8'h00);
    add(1, 0, 8'h00, 0, 1, 0, 8'h00);
    for (int i = 0; i < 8; i++) add(0, 1, 8'(i), 0, 0, (i == 7), 8'h00);
    add(0, 1, 8'hAA, 0, 0, 1, 8'h00);
    for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 1, (i == 7), 0, 8'(i));
    add(0, 0, 8'h00, 1, 1, 0, 8'h07);
    for (int i = 0; i < 8; i++) add(0, 1, 8'(i), 0, 0, (i == 7), 8'h07);
    add(0, 1, 8'h10, 1, 0, 1, 8'h00);
    for (int i = 1; i < 8; i++) add(0, 0, 8'h00, 1, 0, 0, 8'(i));
    add(0, 0, 8'h00, 1, 1, 0, 8'h10);
    add(0, 1, 8'h21, 0, 0, 0, 8'h10);
    add(0, 1, 8'h22, 0, 0, 0, 8'h10);
    add(0, 1, 8'h23, 0, 0, 0, 8'h10);
    add(1, 0, 8'h00, 0, 1, 0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].we, vecs[i].wd, vecs[i].re);
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].f));
      check($sformatf("vec%0d_rdata", i), 32'(read_data), 32'(vecs[i].rd));
`ifdef FIFO_STATUS_EN
      if (i == 10) check("vec_overflow_set", 32'(overflow), 32'h1);
      if (i == 19) check("vec_underflow_set", 32'(underflow), 32'h1);
      if (i == vecs.size() - 2) check("vec_sticky_cleared", 32'({overflow, underflow}), 32'h0);
`endif
    end

    // Read and write together while empty: only the write lands, read_data holds.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h5A, 1);
    check("empty_rw_empty", 32'(empty), 32'h0);
    check("empty_rw_rdata_hold", 32'(read_data), 32'h00);
    step(0, 0, 8'h00, 1);
    check("empty_rw_readback", 32'(read_data), 32'h5A);
    check("empty_rw_empty_after", 32'(empty), 32'h1);

    // Randomized traffic with occasional resets.
    step(1, 0, 8'h00, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r;
      logic we;
      logic re;
      r  = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 99) < ((n / 300) % 2 == 0 ? 70 : 35));
      re = ($urandom_range(0, 99) < ((n / 300) % 2 == 0 ? 35 : 70));
      step(r, we, 8'($urandom), re);
      check_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
